// File: rtl/cmsdk_apb4_eg_timer_regs.sv
// Register block for the APB4 example slave: 32-bit down-counter timer with
// an 8-bit prescaler, reload register, sticky interrupt status and a level irq.
module cmsdk_apb4_eg_timer_regs #(
    parameter int unsigned ADDRWIDTH = 12,
    parameter logic [31:0] ID_VALUE  = 32'h0000_A5E1
) (
    input  logic                 pclk,
    input  logic                 preset,
    input  logic [ADDRWIDTH-1:0] addr,
    input  logic                 read_en,
    input  logic                 write_en,
    input  logic [3:0]           byte_strobe,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic                 irq
);

    typedef enum logic [2:0] {
        SEL_CTRL,
        SEL_VALUE,
        SEL_RELOAD,
        SEL_INTSTATUS,
        SEL_ID,
        SEL_NONE
    } reg_sel_t;

    reg_sel_t             sel;
    logic [ADDRWIDTH-3:0] word_addr;
    logic [1:0]           unused_addr_lsb;

    // Register state
    logic        ctrl_enable;
    logic        ctrl_irq_en;
    logic        ctrl_one_shot;
    logic [7:0]  ctrl_prescale;
    logic [31:0] value;
    logic [31:0] reload;
    logic        int_status;
    logic [7:0]  pre_cnt;

    // Next-state and strobes
    logic        wr_ctrl;
    logic        wr_value;
    logic        wr_reload;
    logic        wr_intstatus;
    logic        tick;
    logic        expire;
    logic        enable_next;
    logic [31:0] value_next;
    logic [31:0] reload_next;
    logic        int_status_next;
    logic [7:0]  pre_cnt_next;

    assign word_addr       = addr[ADDRWIDTH-1:2];
    assign unused_addr_lsb = addr[1:0];

    // Replace only the strobed byte lanes of a register word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strobe);
        logic [31:0] result;
        result = old_word;
        for (int unsigned i = 0; i < 4; i++) begin
            if (strobe[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return result;
    endfunction

    // Address decode: word offset selects one register, everything else is unmapped.
    always_comb begin
        case (word_addr)
            (ADDRWIDTH-2)'(0): sel = SEL_CTRL;
            (ADDRWIDTH-2)'(1): sel = SEL_VALUE;
            (ADDRWIDTH-2)'(2): sel = SEL_RELOAD;
            (ADDRWIDTH-2)'(3): sel = SEL_INTSTATUS;
            (ADDRWIDTH-2)'(4): sel = SEL_ID;
            default:           sel = SEL_NONE;
        endcase
    end

    assign wr_ctrl      = write_en & (sel == SEL_CTRL);
    assign wr_value     = write_en & (sel == SEL_VALUE);
    assign wr_reload    = write_en & (sel == SEL_RELOAD);
    assign wr_intstatus = write_en & (sel == SEL_INTSTATUS);

    assign tick   = ctrl_enable & (pre_cnt == ctrl_prescale);
    assign expire = tick & (value == '0);

    // Counter, prescaler and status next-state; software writes override the
    // tick result lane by lane, while an expiry beats an interrupt clear.
    always_comb begin
        // Prescaler wraps at prescale, idles at 0 when disabled, restarts on CTRL write
        pre_cnt_next = '0;
        if (!wr_ctrl && ctrl_enable && (pre_cnt != ctrl_prescale)) begin
            pre_cnt_next = pre_cnt + 8'd1;
        end

        value_next = value;
        if (tick) begin
            value_next = expire ? reload : (value - 32'd1);
        end
        if (wr_value) begin
            value_next = merge_bytes(value_next, wdata, byte_strobe);
        end

        reload_next = reload;
        if (wr_reload) begin
            reload_next = merge_bytes(reload, wdata, byte_strobe);
        end

        enable_next = ctrl_enable;
        if (expire && ctrl_one_shot) begin
            enable_next = 1'b0;
        end
        if (wr_ctrl && byte_strobe[0]) begin
            enable_next = wdata[0];
        end

        int_status_next = int_status;
        if (wr_intstatus && byte_strobe[0] && wdata[0]) begin
            int_status_next = 1'b0;
        end
        if (expire) begin
            int_status_next = 1'b1;
        end
    end

    // CTRL register: enable may also be cleared by a one-shot expiry.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            ctrl_enable   <= 1'b0;
            ctrl_irq_en   <= 1'b0;
            ctrl_one_shot <= 1'b0;
            ctrl_prescale <= '0;
        end else begin
            ctrl_enable <= enable_next;
            if (wr_ctrl && byte_strobe[0]) begin
                ctrl_irq_en   <= wdata[1];
                ctrl_one_shot <= wdata[2];
            end
            if (wr_ctrl && byte_strobe[1]) begin
                ctrl_prescale <= wdata[15:8];
            end
        end
    end

    // Counter, reload, prescaler and sticky interrupt status.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            value      <= '0;
            reload     <= '0;
            pre_cnt    <= '0;
            int_status <= 1'b0;
        end else begin
            value      <= value_next;
            reload     <= reload_next;
            pre_cnt    <= pre_cnt_next;
            int_status <= int_status_next;
        end
    end

    // Read mux: zero whenever no read is in progress.
    always_comb begin
        rdata = '0;
        if (read_en) begin
            case (sel)
                SEL_CTRL:      rdata = {16'h0000, ctrl_prescale, 5'b00000,
                                        ctrl_one_shot, ctrl_irq_en, ctrl_enable};
                SEL_VALUE:     rdata = value;
                SEL_RELOAD:    rdata = reload;
                SEL_INTSTATUS: rdata = {31'h0, int_status};
                SEL_ID:        rdata = ID_VALUE;
                default:       rdata = '0;
            endcase
        end
    end

    assign irq = int_status & ctrl_irq_en;

endmodule

// File: tb/tb_cmsdk_apb4_eg_timer_regs.sv
// Scoreboard bench for the timer register block: a driver issues register
// accesses and queues expected read data from a register-map model; a
// monitor compares rdata on every read cycle and irq on every cycle.
module tb_cmsdk_apb4_eg_timer_regs;

    localparam logic [31:0] ID = 32'h0000_A5E1;

    logic        pclk;
    logic        preset;
    logic [11:0] addr;
    logic        read_en;
    logic        write_en;
    logic [3:0]  byte_strobe;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int checks;
    int failures;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;
    exp_t sb_q[$];

    // Register-map model: word 0 CTRL, 1 VALUE, 2 RELOAD, 3 INTSTATUS.
    logic [31:0] m_reg [0:3];
    logic [7:0]  m_pre;

    cmsdk_apb4_eg_timer_regs #(
        .ADDRWIDTH(12),
        .ID_VALUE (32'h0000_A5E1)
    ) dut (
        .pclk       (pclk),
        .preset     (preset),
        .addr       (addr),
        .read_en    (read_en),
        .write_en   (write_en),
        .byte_strobe(byte_strobe),
        .wdata      (wdata),
        .rdata      (rdata),
        .irq        (irq)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = '0;
        m_pre = '0;
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a);
        int unsigned w;
        w = int'(a[11:2]);
        if (w < 4) return m_reg[w];
        if (w == 4) return ID;
        return '0;
    endfunction

    // One clock edge of the register map as seen by software.
    function automatic void model_edge(input logic we, input logic [11:0] a,
                                       input logic [3:0] bs, input logic [31:0] wd);
        int unsigned w;
        logic [31:0] nxt [0:3];
        logic [7:0]  presc;
        logic        en;
        logic        tk;
        logic [7:0]  npre;
        w     = int'(a[11:2]);
        presc = m_reg[0][15:8];
        en    = m_reg[0][0];
        tk    = en && (m_pre == presc);
        npre  = (en && (m_pre != presc)) ? m_pre + 8'd1 : 8'd0;
        for (int i = 0; i < 4; i++) nxt[i] = m_reg[i];
        if (we && w == 3 && bs[0] && wd[0]) nxt[3] = '0;
        if (tk) begin
            if (m_reg[1] != 0) begin
                nxt[1] = m_reg[1] - 1;
            end else begin
                nxt[1] = m_reg[2];
                nxt[3] = 32'd1;
                if (m_reg[0][2]) nxt[0][0] = 1'b0;
            end
        end
        if (we && w < 3) begin
            for (int b = 0; b < 4; b++)
                if (bs[b]) nxt[w][8*b +: 8] = wd[8*b +: 8];
            if (w == 0) begin
                nxt[0] = nxt[0] & 32'h0000_FF07;
                npre   = '0;
            end
        end
        for (int i = 0; i < 4; i++) m_reg[i] = nxt[i];
        m_pre = npre;
    endfunction

    // One bus cycle; entered and left 1 time unit after a rising edge.
    task automatic op(input logic we, input logic re, input logic [11:0] a,
                      input logic [3:0] bs, input logic [31:0] wd,
                      input logic use_c, input logic [31:0] c, input string nm);
        exp_t e;
        write_en    = we;
        read_en     = re;
        addr        = a;
        byte_strobe = bs;
        wdata       = wd;
        if (re) begin
            e.name = nm;
            e.exp  = use_c ? c : model_read(a);
            sb_q.push_back(e);
        end
        @(posedge pclk);
        if (!preset) model_edge(we, a, bs, wd);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [3:0] bs, input logic [31:0] wd);
        op(1'b1, 1'b0, a, bs, wd, 1'b0, '0, "");
    endtask

    task automatic rd(input logic [11:0] a, input string nm);
        op(1'b0, 1'b1, a, 4'h0, '0, 1'b0, '0, nm);
    endtask

    task automatic rdc(input logic [11:0] a, input logic [31:0] c, input string nm);
        op(1'b0, 1'b1, a, 4'h0, '0, 1'b1, c, nm);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(1'b0, 1'b0, 12'h000, 4'h0, '0, 1'b0, '0, "");
    endtask

    // Asynchronous reset asserted mid-cycle, released just after an edge.
    task automatic async_reset();
        #2;
        preset   = 1'b1;
        write_en = 1'b0;
        read_en  = 1'b0;
        model_reset();
        @(posedge pclk);
        @(posedge pclk);
        #1;
        preset = 1'b0;
    endtask

    // Monitor: irq every cycle, rdata whenever a read is presented.
    always @(negedge pclk) begin
        exp_t e;
        logic exp_irq;
        exp_irq = m_reg[3][0] & m_reg[0][1];
        checks++;
        if (irq !== exp_irq) begin
            failures++;
            $display("FAIL irq t=%0t got=%b exp=%b", $time, irq, exp_irq);
        end
        if (read_en) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL read_unexpected t=%0t got=%h", $time, rdata);
            end else begin
                e = sb_q.pop_front();
                if (rdata !== e.exp) begin
                    failures++;
                    $display("FAIL %s t=%0t got=%h exp=%h", e.name, $time, rdata, e.exp);
                end
            end
        end
    end

    initial begin
        logic found;
        int   expiries;
        int unsigned r;
        int unsigned w;
        logic [31:0] d;
        checks      = 0;
        failures    = 0;
        preset      = 1'b1;
        addr        = '0;
        read_en     = 1'b0;
        write_en    = 1'b0;
        byte_strobe = '0;
        wdata       = '0;
        model_reset();
        @(posedge pclk);
        @(posedge pclk);
        #1;
        preset = 1'b0;

        // Byte-lane writes
        wr(12'h008, 4'b1111, 32'h1122_3344);
        wr(12'h008, 4'b0101, 32'hFFFF_FFFF);
        rdc(12'h008, 32'h11FF_33FF, "reload_lanes");
        wr(12'h008, 4'b0000, 32'hDEAD_BEEF);
        rdc(12'h00A, 32'h11FF_33FF, "reload_nostrobe");

        // Periodic count
        wr(12'h008, 4'hF, 32'd3);
        wr(12'h004, 4'hF, 32'd3);
        wr(12'h000, 4'hF, 32'h0000_0003);
        rdc(12'h004, 32'd3, "periodic_v3");
        rdc(12'h004, 32'd2, "periodic_v2");
        rdc(12'h004, 32'd1, "periodic_v1");
        rdc(12'h004, 32'd0, "periodic_v0");
        rdc(12'h004, 32'd3, "periodic_reload");
        for (int i = 0; i < 8; i++) rd(12'h004, "periodic_run");
        rd(12'h000, "periodic_ctrl");

        // Reset mid-count, then readback
        async_reset();
        rdc(12'h000, 32'h0, "rst_ctrl");
        rdc(12'h004, 32'h0, "rst_value");
        rdc(12'h008, 32'h0, "rst_reload");
        rdc(12'h00C, 32'h0, "rst_intstatus");
        rdc(12'h010, ID,    "rst_id");
        rdc(12'h020, 32'h0, "unmapped_020");
        wr(12'h010, 4'hF, 32'h1234_5678);
        rdc(12'h010, ID, "id_readonly");
        idle(3);
        rdc(12'h004, 32'h0, "rst_no_count");

        // Clear versus set collision on the second expiry
        wr(12'h008, 4'hF, 32'd3);
        wr(12'h004, 4'hF, 32'd3);
        wr(12'h000, 4'hF, 32'h0000_0003);
        expiries = 0;
        found    = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_reg[0][0] && m_pre == m_reg[0][15:8] && m_reg[1] == 0) begin
                expiries++;
                if (expiries == 2) begin
                    wr(12'h00C, 4'h1, 32'h1);
                    found = 1'b1;
                end else begin
                    idle(1);
                end
            end else begin
                idle(1);
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL collision_search got=%0d exp=2 expiries", expiries);
        end
        rdc(12'h00C, 32'h1, "clear_vs_set");
        wr(12'h000, 4'hF, 32'h0000_0002);
        idle(2);
        wr(12'h00C, 4'h1, 32'h1);
        rdc(12'h00C, 32'h0, "clear_later");
        idle(2);

        // Write/tick collision
        wr(12'h004, 4'hF, 32'd5);
        wr(12'h000, 4'hF, 32'h0000_0001);
        wr(12'h004, 4'hF, 32'h0000_0100);
        rdc(12'h004, 32'h0000_0100, "write_beats_tick");
        rdc(12'h004, 32'h0000_00FF, "after_write_tick");

        // Prescaler and one-shot
        wr(12'h000, 4'hF, 32'h0);
        wr(12'h00C, 4'h1, 32'h1);
        wr(12'h008, 4'hF, 32'd3);
        wr(12'h004, 4'hF, 32'd2);
        wr(12'h000, 4'hF, 32'h0000_0407);
        for (int i = 0; i < 15; i++) rd(12'h004, "oneshot_count");
        rdc(12'h000, 32'h0000_0406, "oneshot_ctrl");
        rdc(12'h00C, 32'h1, "oneshot_int");
        rdc(12'h004, 32'd3, "oneshot_value");
        idle(8);
        rdc(12'h004, 32'd3, "oneshot_stopped");
        wr(12'h00C, 4'h1, 32'h1);

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 99);
            w = $urandom_range(0, 8);
            if (r < 40) begin
                rd(12'(w * 4 + $urandom_range(0, 3)), "rand_read");
            end else if (r < 75) begin
                w = $urandom_range(0, 5);
                d = $urandom;
                if (w == 0) d[15:8] = 8'($urandom_range(0, 3));
                else if (w < 3 && $urandom_range(0, 3) != 0) d = $urandom_range(0, 12);
                wr(12'(w * 4), 4'($urandom_range(0, 15)), d);
            end else if (r < 99) begin
                idle(1);
            end else begin
                async_reset();
            end
        end

        idle(2);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0 pending", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmsdk_apb4_eg_timer_regs.md
# cmsdk_apb4_eg_timer_regs

Register-side consumer of the APB4 example slave interface's simple register protocol (`addr`, `read_en`, `write_en`, `byte_strobe`, `wdata`, `rdata`). It implements a memory-mapped 32-bit down-counter timer with:
- an 8-bit prescaler,
- a reload register,
- a sticky interrupt status bit,
- a level interrupt output.

All register state lives here; the interface stage supplies decoded access strobes and returns `rdata` onto `prdata` unregistered.

## Interface
- ADDRWIDTH, 12, width of `addr`; decode uses `addr[ADDRWIDTH-1:2]`, and `addr[1:0]` is ignored.
- ID_VALUE, 32'h0000_A5E1, constant returned by the ID register.

Ports:
- pclk  input  1  clock; all state updates on its rising edge.
- preset  input  1  asynchronous, active-high reset.
- addr  input  ADDRWIDTH  register byte address.
- read_en  input  1  read access; high for the whole APB read transfer.
- write_en  input  1  write strobe; high for exactly one cycle per write.
- byte_strobe  input  4  write byte lanes; bit n enables `wdata[8n+7:8n]`.
- wdata  input  32  write data.
- rdata  output  32  read data; combinational from `addr` and register state.
- irq  output  1  interrupt, equal to `int_status & CTRL.irq_en`.

## Operation
Register map (word offsets):
- 0x000 CTRL
  - [0] enable, [1] irq_en, [2] one_shot, [15:8] prescale.
  - All other bits read 0 and ignore writes.
- 0x004 VALUE: 32-bit counter, R/W.
- 0x008 RELOAD: 32-bit, R/W.
- 0x00C INTSTATUS
  - [0] int_status; reads return it, other bits read 0.
  - Writing 1 to bit 0 (lane 0 strobed) clears it; writing 0 has no effect.
- 0x010 ID: read-only, returns ID_VALUE; writes ignored.
- Any other offset: reads return 0, writes ignored, no error.

Access rules:
- Reads: `rdata = read_en ? mux(addr) : 32'h0`. Reads have no side effects.
- Writes occur on the `pclk` edge where `write_en` = 1.
  - Only strobed bytes change.
  - `byte_strobe` = 4'b0000 leaves the register unchanged.

Prescaler:
- `pre_cnt` is 8 bits.
- While enable = 0, `pre_cnt` is held at 0.
- While enable = 1, `pre_cnt` counts 0..prescale and wraps to 0.
- `tick` = enable & (`pre_cnt` == prescale). With prescale = 0, `tick` asserts every cycle.
- Any write to CTRL resets `pre_cnt` to 0.

Counter, on a tick:
- If VALUE != 0: VALUE <= VALUE − 1.
- If VALUE == 0:
  - VALUE <= RELOAD and int_status <= 1.
  - If one_shot = 1, enable <= 0; RELOAD is still loaded.
- With RELOAD = 0 in periodic mode, int_status sets on every tick.

Simultaneous events:
- A VALUE write and a tick in the same cycle: the written bytes win; unwritten bytes take the tick result.
- A CTRL write and a one-shot auto-clear in the same cycle: the written enable value wins.
- An INTSTATUS clear and an expiry in the same cycle: int_status ends at 1 (set wins).
- A RELOAD write and an expiry in the same cycle: VALUE loads the old RELOAD.

## Timing
- Reset (asynchronous assert) clears CTRL, VALUE, RELOAD, int_status and `pre_cnt` to 0.
  - Output values during reset: `irq` = 0, and `rdata` = 0 when `read_en` = 0.
  - Reset asserted mid-count abandons the count immediately.
  - After release, the first tick requires software to set enable.
- Write latency: register contents reflect a write in the cycle after the `write_en` edge.
  - A read in the APB access phase of a following transfer sees the new value.
- Read latency: zero cycles. `rdata` is valid in the same cycle as `read_en` and `addr`, both APB phases.
- Counting cadence: with prescale = P, VALUE decrements once every P+1 cycles.
  - The first tick after enable is written 1 occurs P+1 edges after the write edge.
- `irq` timing:
  - Rises in the cycle after the expiry edge.
  - Falls in the cycle after the clearing write, or after the irq_en = 0 write.
  - Driven only from flops, so it is glitch-free.

## Test plan
- Reset and readback:
  - Assert `preset` mid-count.
  - Required: `irq` = 0 and every register reads 0, except ID = 32'h0000_A5E1.
  - An unmapped read at offset 0x020 returns 0.
- Byte-lane writes:
  - Write RELOAD = 32'h1122_3344 with strobe 4'b1111, then write 32'hFFFF_FFFF with strobe 4'b0101.
  - Required: RELOAD reads 32'h11FF_33FF.
- Periodic count:
  - RELOAD = 3, VALUE = 3, CTRL = 0x0003 (prescale 0).
  - Required: VALUE reads 3, 2, 1, 0 on successive cycles, then 3.
  - `irq` rises 1 cycle after the 0→3 reload and recurs every 4 cycles.
- Prescaler and one-shot:
  - VALUE = 2, CTRL = 0x0407 (prescale 4, one_shot).
  - Required: a decrement every 5 cycles.
  - After 15 cycles: int_status = 1, VALUE = RELOAD, CTRL.enable = 0, and counting stops.
- Clear versus set collision:
  - Write INTSTATUS = 1 on the same edge as an expiry.
  - Required: int_status stays 1 and `irq` stays high.
  - A later clear write drops `irq` one cycle after its edge.
- Write/tick collision:
  - Write VALUE = 32'h100 on a tick edge with VALUE = 5.
  - Required: VALUE reads 32'h100, not 4.
